// File: rtl/vr_bus_pkg.sv
// ---------------------------------------------------------------------------
// vr_bus_pkg
// Shared definitions for both ends of the valid/ready bus: the control-state
// encoding used by bus sources and the handshake qualifier that decides
// whether a beat moves on a given clock edge.
// ---------------------------------------------------------------------------
package vr_bus_pkg;

  // Encodings are fixed so that state values read the same on both sides of
  // the bus when probed or logged.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } vr_state_e;

  // A beat transfers on a rising edge where both handshake signals are high.
  function automatic logic fire(input logic valid, input logic ready);
    return valid && ready;
  endfunction

endpackage : vr_bus_pkg

// File: rtl/vr_burst_source.sv
// ---------------------------------------------------------------------------
// vr_burst_source
// Valid/ready stream source. A start request in IDLE launches a burst of
// len_i beats whose data counts up from base_i (wrapping at 2^DATA_W). The
// final beat carries m_last_o. Once the last beat is accepted, done_o pulses
// for one cycle and the block waits GAP_CYC idle cycles before it accepts
// another request. abort_i ends a burst early without a done_o pulse.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start_i    burst request, sampled only in IDLE
//   len_i      beat count, sampled with start_i (0 = ignore request)
//   base_i     first data value, sampled with start_i
//   abort_i    end the current burst (has effect only in SEND)
//   busy_o     high while in SEND or GAP
//   done_o     one-cycle pulse after the last beat is accepted
//   m_valid_o  stream valid
//   m_data_o   stream data
//   m_last_o   marks the final beat of the burst
//   m_ready_i  sink ready
//
// Every output comes straight from a flop, so there is no combinational path
// from m_ready_i or start_i to an output.
// ---------------------------------------------------------------------------
module vr_burst_source
  import vr_bus_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int LEN_W   = 8,
  parameter int GAP_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [DATA_W-1:0] base_i,
  input  logic              abort_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              m_valid_o,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_last_o,
  input  logic              m_ready_i
);

  // The gap counter is loaded with GAP_CYC-1 and counts down to zero, so GAP
  // lasts exactly GAP_CYC cycles. It keeps at least one bit so that the
  // declaration stays legal when GAP_CYC is 0 or 1.
  localparam int              GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  vr_state_e         state_q, state_d;
  logic [LEN_W-1:0]  rem_q,   rem_d;    // beats still to deliver, current beat included
  logic [GAP_W-1:0]  gap_q,   gap_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic              last_q,  last_d;
  logic              busy_q,  busy_d;
  logic              done_q,  done_d;
  logic              xfer;

  assign xfer = fire(valid_q, m_ready_i);

  // NOTE: every next-state signal gets its hold value first. Any path through
  // the case statement that skips an assignment then holds the value instead
  // of inferring a latch.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    gap_d   = gap_q;
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // A zero-length request is dropped. m_ready_i does not matter here.
        if (start_i && (len_i != '0)) begin
          state_d = ST_SEND;
          rem_d   = len_i;
          valid_d = 1'b1;
          data_d  = base_i;
          last_d  = (len_i == LEN_W'(1));
          busy_d  = 1'b1;
        end
      end

      ST_SEND: begin
        if (abort_i) begin
          // Abort takes priority over a transfer on the same edge. That beat
          // has still gone out on the bus, but the burst ends here.
          state_d = ST_IDLE;
          rem_d   = '0;
          valid_d = 1'b0;
          data_d  = '0;
          last_d  = 1'b0;
          busy_d  = 1'b0;
        end else if (xfer) begin
          if (last_q) begin
            rem_d   = '0;
            valid_d = 1'b0;
            data_d  = '0;
            last_d  = 1'b0;
            done_d  = 1'b1;
            if (GAP_CYC == 0) begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
            end else begin
              state_d = ST_GAP;
              gap_d   = GAP_LOAD;
            end
          end else begin
            // The data counter wraps naturally at the register width.
            data_d = data_q + DATA_W'(1);
            rem_d  = rem_q - LEN_W'(1);
            last_d = (rem_q == LEN_W'(2));
          end
        end
        // With valid high and ready low nothing changes, so data and last
        // hold steady through the stall.
      end

      ST_GAP: begin
        // start_i is ignored here and is not queued.
        if (gap_q == '0) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        rem_d   = '0;
        gap_d   = '0;
        valid_d = 1'b0;
        data_d  = '0;
        last_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. All flops then
  // update together at the edge, and no flop sees another flop's new value in
  // the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      gap_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      gap_q   <= gap_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign m_valid_o = valid_q;
  assign m_data_o  = data_q;
  assign m_last_o  = last_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

endmodule : vr_burst_source

// File: doc/vr_burst_source.md
Name: vr_burst_source

Overview:
Valid/ready stream transmitter: the source side of the team's valid/ready bus, driving a destination that samples data on valid && ready.
- On a start request, emits a burst of len_i beats of incrementing data starting at base_i.
- Marks the final beat with m_last_o, then enforces an inter-burst gap.
- Sits between a local control FSM (start/len/base) and any valid/ready sink, including the destination stage of the team's bus.

Parameters:
DATA_W, 8, width of m_data_o and base_i
LEN_W, 8, width of len_i and the internal remaining-beat counter
GAP_CYC, 2, idle cycles between the last accepted beat and the next possible start; 0 allowed

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  reset, asynchronous, active-low
start_i  input  1  burst request, sampled only in IDLE
len_i  input  LEN_W  beat count, sampled with start_i; 0 means ignore the request
base_i  input  DATA_W  first data value, sampled with start_i
abort_i  input  1  terminate the current burst
busy_o  output  1  high in SEND and GAP
done_o  output  1  one-cycle pulse after the last beat is accepted
m_valid_o  output  1  stream valid
m_data_o  output  DATA_W  stream data
m_last_o  output  1  final beat of the burst
m_ready_i  input  1  sink ready

Behaviour:
- Reset (async, while rst_n=0):
  - state=IDLE
  - m_valid_o=0, m_data_o=0, m_last_o=0, busy_o=0, done_o=0
  - counters=0
  - Reset mid-burst discards the burst; no done_o.
- Outputs are registered only; no combinational path from m_ready_i or start_i to any output.
- States: IDLE, SEND, GAP.
- IDLE:
  - start_i=1 and len_i!=0 at edge N: latch len/base, enter SEND. m_valid_o=1, m_data_o=base_i, m_last_o=(len_i==1) after edge N (first-beat latency 1 cycle).
  - start_i with len_i=0: ignored, stays IDLE.
  - m_ready_i is ignored.
- SEND:
  - A beat transfers on an edge where m_valid_o && m_ready_i.
  - Stall rule: while m_valid_o && !m_ready_i, m_data_o and m_last_o stay stable. m_valid_o never drops without a transfer, except on abort or reset.
  - Non-last transfer: m_data_o increments by 1, wrapping modulo 2^DATA_W (0xFF -> 0x00 for DATA_W=8). Remaining count decrements. m_last_o=1 when remaining becomes 1. Back-to-back transfers give one beat per cycle.
  - Last transfer (m_last_o=1): next cycle m_valid_o=0, m_last_o=0, m_data_o=0, done_o=1 for exactly one cycle. Next state is GAP, or IDLE if GAP_CYC=0.
  - abort_i=1: next cycle m_valid_o=0, m_last_o=0, m_data_o=0, state IDLE, no done_o. Abort wins over a simultaneous transfer; that beat counts as delivered on the bus, but the burst ends.
- GAP:
  - Counts GAP_CYC cycles, then IDLE. start_i is ignored (not queued) during GAP and SEND.
  - abort_i is ignored in IDLE and GAP.
- busy_o is registered: 1 in SEND and GAP, 0 in IDLE.
- Maximum burst: 2^LEN_W-1 beats.

Decomposition:
- Shared include/package (vr_bus_pkg): state encodings (IDLE=2'd0, SEND=2'd1, GAP=2'd2) and the handshake macro/function fire = valid && ready, shared with the destination side.
- No sub-module: the FSM, beat counter and gap counter are small enough to live in one module.

Test Plan:
1. Reset, then start_i with len=4, base=0x10, m_ready_i=1 -> data 0x10,0x11,0x12,0x13 on 4 consecutive cycles; m_last_o only on 0x13; done_o one cycle later; busy_o low 2 cycles after done_o.
2. len=3, base=0x20; m_ready_i low for 3 cycles during beat 2 -> m_data_o holds 0x21 with m_valid_o=1 throughout the stall; totals 3 beats; m_last_o on 0x22.
3. len=3, base=0xFE -> data 0xFE,0xFF,0x00; m_last_o on 0x00.
4. len=1 -> a single beat with m_valid_o and m_last_o together; start_i held high during SEND/GAP produces no second burst until IDLE; start_i with len=0 in IDLE -> no m_valid_o.
5. Abort in the middle of len=8 (after 3 beats) -> m_valid_o=0 the next cycle, state IDLE, no done_o; a new start is accepted immediately.
6. Drop rst_n mid-burst -> outputs immediately 0; after release, a new start yields a clean burst from base.
